sd_cmd_ctrl: RTL and testbench

SD_CMD_CTRL -- requirements
Module: sd_cmd_ctrl

---
 rtl/sd_cmd_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// rtl/sd_cmd_ctrl.sv - SD CMD-line controller: 48-bit command out, 48/136-bit response in
// Receive CRC7 checking is built only when SD_CMD_CRC_CHECK_EN is defined.
module sd_cmd_ctrl #(
   parameter int CLK_DIV     = 4,
   parameter int RSP_TIMEOUT = 64,
   parameter int NCC         = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_start,
   input  logic [5:0]   cmd_idx,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   rsp_type,
   output logic         busy,
   output logic         done,
   output logic [127:0] rsp_data,
   output logic         err_timeout,
   output logic         err_crc,
   output logic         sd_clk,
   output logic         sd_cmd_out_o,
   output logic         sd_cmd_oe,
   input  logic         sd_cmd_dat_i
);
   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [15:0]      TO_LAST  = 16'(RSP_TIMEOUT - 1);
   localparam logic [15:0]      GAP_LAST = 16'(2 * NCC - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;
   state_t state, state_nxt;

   logic [DIV_W-1:0] div_cnt;
   logic             tick, rise_tick, fall_tick;
   logic [15:0]      cnt;
   logic [15:0]      rx_last;
   logic [47:0]      tx_shift;
   logic [1:0]       type_q;
   logic             send_last, wait_hit, wait_last, recv_last, gap_last;
`ifdef SD_CMD_CRC_CHECK_EN
   logic [6:0]       rx_crc;
`endif

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   // sd_clk is free-running; a tick marks the clk cycle on which sd_clk flips.
   assign tick      = (div_cnt == DIV_LAST);
   assign rise_tick = tick && !sd_clk;
   assign fall_tick = tick && sd_clk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         sd_clk  <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         sd_clk  <= ~sd_clk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign rx_last   = (type_q == 2'b10) ? 16'd135 : 16'd47;
   assign send_last = fall_tick && (cnt == 16'd48);
   assign wait_hit  = rise_tick && !sd_cmd_dat_i;
   assign wait_last = rise_tick && sd_cmd_dat_i && (cnt == TO_LAST);
   assign recv_last = rise_tick && (cnt == rx_last);
   // GAP counts sd_clk half-periods so NCC full cycles elapse whichever edge it starts on.
   assign gap_last  = tick && (cnt == GAP_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cmd_start) state_nxt = SEND;
         SEND: if (send_last) state_nxt = (type_q == 2'b00) ? GAP : WAIT;
         WAIT: begin
            if (wait_hit)       state_nxt = RECV;
            else if (wait_last) state_nxt = GAP;
         end
         RECV: if (recv_last) state_nxt = GAP;
         GAP:  if (gap_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy         <= 1'b0;
         done         <= 1'b0;
         rsp_data     <= '0;
         err_timeout  <= 1'b0;
         sd_cmd_out_o <= 1'b1;
         sd_cmd_oe    <= 1'b0;
         cnt          <= '0;
         tx_shift     <= '0;
         type_q       <= '0;
`ifdef SD_CMD_CRC_CHECK_EN
         err_crc      <= 1'b0;
         rx_crc       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (cmd_start) begin
               tx_shift    <= {2'b01, cmd_idx, cmd_arg, crc7_40({2'b01, cmd_idx, cmd_arg}), 1'b1};
               type_q      <= rsp_type;
               busy        <= 1'b1;
               err_timeout <= 1'b0;
               cnt         <= '0;
`ifdef SD_CMD_CRC_CHECK_EN
               err_crc     <= 1'b0;
`endif
            end
            SEND: if (fall_tick) begin
               if (cnt == 16'd48) begin
                  sd_cmd_oe    <= 1'b0;
                  sd_cmd_out_o <= 1'b1;
                  cnt          <= '0;
               end else begin
                  sd_cmd_oe    <= 1'b1;
                  sd_cmd_out_o <= tx_shift[47];
                  tx_shift     <= {tx_shift[46:0], 1'b0};
                  cnt          <= cnt + 16'd1;
               end
            end
            WAIT: begin
               if (wait_hit) begin
                  rsp_data <= '0;
                  cnt      <= 16'd1;
`ifdef SD_CMD_CRC_CHECK_EN
                  rx_crc   <= '0;
`endif
               end else if (wait_last) begin
                  err_timeout <= 1'b1;
                  cnt         <= '0;
               end else if (rise_tick) begin
                  cnt <= cnt + 16'd1;
               end
            end
            RECV: if (rise_tick) begin
               if (recv_last) begin
                  cnt <= '0;
                  if (type_q == 2'b10) rsp_data <= {rsp_data[126:0], sd_cmd_dat_i};
                  else                 rsp_data <= {82'b0, rsp_data[44:0], sd_cmd_dat_i};
`ifdef SD_CMD_CRC_CHECK_EN
                  // rsp_data[6:0] currently holds received frame bits 7..1
                  if (type_q == 2'b01 && rx_crc != rsp_data[6:0]) err_crc <= 1'b1;
`endif
               end else begin
                  rsp_data <= {rsp_data[126:0], sd_cmd_dat_i};
                  cnt      <= cnt + 16'd1;
`ifdef SD_CMD_CRC_CHECK_EN
                  if (cnt < 16'd40) rx_crc <= crc7_step(rx_crc, sd_cmd_dat_i);
`endif
               end
            end
            GAP: if (tick) begin
               if (cnt == GAP_LAST) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  cnt  <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SD_CMD_CRC_CHECK_EN
   assign err_crc = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb/tb_sd_cmd_ctrl.sv - randomized self-checking bench for sd_cmd_ctrl with an SD card model
`timescale 1ns/1ps
module tb_sd_cmd_ctrl;
   localparam int CLK_DIV     = 4;
   localparam int RSP_TIMEOUT = 64;
   localparam int NCC         = 8;
`ifdef SD_CMD_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         cmd_start;
   logic [5:0]   cmd_idx;
   logic [31:0]  cmd_arg;
   logic [1:0]   rsp_type;
   logic         busy;
   logic         done;
   logic [127:0] rsp_data;
   logic         err_timeout;
   logic         err_crc;
   logic         sd_clk;
   logic         sd_cmd_out_o;
   logic         sd_cmd_oe;
   logic         sd_cmd_dat_i;

   int           checks = 0;
   int           errors = 0;
   int           done_cnt = 0;
   int           fall_cnt = 0;
   int           rise_cnt = 0;
   logic [127:0] exp_rsp = '0;

   sd_cmd_ctrl #(.CLK_DIV(CLK_DIV), .RSP_TIMEOUT(RSP_TIMEOUT), .NCC(NCC)) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
      .rsp_type(rsp_type), .busy(busy), .done(done), .rsp_data(rsp_data),
      .err_timeout(err_timeout), .err_crc(err_crc), .sd_clk(sd_clk),
      .sd_cmd_out_o(sd_cmd_out_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_dat_i(sd_cmd_dat_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(negedge clk) if (done === 1'b1) done_cnt++;
   always @(negedge sd_clk) fall_cnt++;
   always @(posedge sd_clk) rise_cnt++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1
   function automatic logic [6:0] crc7_div(input logic [39:0] d);
      logic [46:0] r;
      r = {d, 7'b0};
      for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
      return r[6:0];
   endfunction

   function automatic logic [47:0] exp_cmd(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, crc7_div({2'b01, idx, arg}), 1'b1};
   endfunction

   function automatic logic exp_crc_err(input logic [1:0] typ, input logic [47:0] f);
      return CRC_EN && (typ == 2'b01) && (crc7_div(f[47:8]) != f[7:1]);
   endfunction

   // Issues one command, captures the CMD line, plays the card's response, waits for done.
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                          input bit respond, input logic [135:0] frame, input int flen, input int dly,
                          output logic [47:0] cap, output int falls, output int rises,
                          output int dones, output bit got_done, output bit oe_bad,
                          output logic busy_seen, output logic [1:0] errs_at_start);
      int d0, f0, r0, n;
      cap = '0;
      oe_bad = 1'b0;
      @(negedge clk);
      cmd_idx = idx; cmd_arg = arg; rsp_type = typ; cmd_start = 1'b1;
      d0 = done_cnt;
      @(negedge clk);
      cmd_start = 1'b0;
      busy_seen = busy;
      errs_at_start = {err_timeout, err_crc};
      n = 0;
      while (sd_cmd_oe !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      f0 = fall_cnt;
      r0 = rise_cnt;
      for (int i = 0; i < 48; i++) begin
         @(posedge sd_clk); @(negedge clk);
         cap = {cap[46:0], sd_cmd_out_o};
         if (sd_cmd_oe !== 1'b1) oe_bad = 1'b1;
      end
      if (respond) begin
         repeat (dly) @(negedge sd_clk);
         for (int i = flen - 1; i >= 0; i--) begin
            @(negedge sd_clk); @(negedge clk);
            sd_cmd_dat_i = frame[i];
            if (sd_cmd_oe !== 1'b0) oe_bad = 1'b1;
         end
         @(negedge sd_clk); @(negedge clk);
         sd_cmd_dat_i = 1'b1;
      end
      n = 0;
      while (done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      got_done = (done === 1'b1);
      falls = fall_cnt - f0;
      rises = rise_cnt - r0;
      repeat (4 * CLK_DIV) @(negedge clk);
      dones = done_cnt - d0;
   endtask

   task automatic test_reset();
      rst = 1'b0; cmd_start = 1'b0; cmd_idx = '0; cmd_arg = '0; rsp_type = '0; sd_cmd_dat_i = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (sd_clk !== 1'b0) begin errors++; $display("FAIL reset_sd_clk: got %b want 0", sd_clk); end
      checks++; if (sd_cmd_out_o !== 1'b1 || sd_cmd_oe !== 1'b0) begin errors++; $display("FAIL reset_cmd_line: got out=%b oe=%b want out=1 oe=0", sd_cmd_out_o, sd_cmd_oe); end
      checks++; if ({busy, done, err_timeout, err_crc} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got busy/done/tmo/crc=%b want 0000", {busy, done, err_timeout, err_crc}); end
      checks++; if (rsp_data !== 128'b0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      rst = 1'b1;
      repeat (CLK_DIV - 1) @(negedge clk);
      checks++; if (sd_clk !== 1'b0) begin errors++; $display("FAIL div_early: got sd_clk=%b want 0 after %0d clk", sd_clk, CLK_DIV - 1); end
      @(negedge clk);
      checks++; if (sd_clk !== 1'b1) begin errors++; $display("FAIL div_toggle: got sd_clk=%b want 1 after %0d clk", sd_clk, CLK_DIV); end
   endtask

   task automatic test_cmd0();
      logic [47:0] cap; int falls, rises, dones; bit gd, ob; logic bs; logic [1:0] es;
      run_cmd(6'd0, 32'h0, 2'b00, 1'b0, '0, 48, 1, cap, falls, rises, dones, gd, ob, bs, es);
      checks++; if (bs !== 1'b1) begin errors++; $display("FAIL cmd0_busy: got %b want 1", bs); end
      checks++; if (cap !== 48'h400000000095) begin errors++; $display("FAIL cmd0_frame: got %h want 400000000095", cap); end
      checks++; if (ob) begin errors++; $display("FAIL cmd0_oe: got oe glitch during frame want steady 1"); end
      checks++; if (!gd || falls != 48 + NCC) begin errors++; $display("FAIL cmd0_done_time: got done=%0d after %0d sd_clk want %0d", gd, falls, 48 + NCC); end
      checks++; if (dones != 1) begin errors++; $display("FAIL cmd0_done_count: got %0d want 1", dones); end
      checks++; if ({err_timeout, err_crc, busy} !== 3'b000) begin errors++; $display("FAIL cmd0_flags: got tmo/crc/busy=%b want 000", {err_timeout, err_crc, busy}); end
   endtask

   task automatic test_timeout();
      logic [47:0] cap; int falls, rises, dones; bit gd, ob; logic bs; logic [1:0] es;
      run_cmd(6'd55, 32'h0, 2'b01, 1'b0, '0, 48, 1, cap, falls, rises, dones, gd, ob, bs, es);
      checks++; if (cap !== exp_cmd(6'd55, 32'h0)) begin errors++; $display("FAIL tmo_frame: got %h want %h", cap, exp_cmd(6'd55, 32'h0)); end
      checks++; if (err_timeout !== 1'b1 || err_crc !== 1'b0) begin errors++; $display("FAIL tmo_flags: got tmo=%b crc=%b want 1 0", err_timeout, err_crc); end
      checks++; if (!gd || rises != 48 + RSP_TIMEOUT + NCC) begin errors++; $display("FAIL tmo_time: got done=%0d after %0d rises want %0d", gd, rises, 48 + RSP_TIMEOUT + NCC); end
      checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL tmo_rsp_data: got %h want %h", rsp_data, exp_rsp); end
      checks++; if (dones != 1) begin errors++; $display("FAIL tmo_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_cmd8(input logic [47:0] rsp, input logic exp_err, input string tag);
      logic [47:0] cap; int falls, rises, dones; bit gd, ob; logic bs; logic [1:0] es;
      run_cmd(6'd8, 32'h000001AA, 2'b01, 1'b1, {88'b0, rsp}, 48, 2, cap, falls, rises, dones, gd, ob, bs, es);
      exp_rsp = {82'b0, rsp[45:0]};
      checks++; if (es !== 2'b00) begin errors++; $display("FAIL %s_clear: got tmo/crc=%b at accept want 00", tag, es); end
      checks++; if (cap !== exp_cmd(6'd8, 32'h000001AA)) begin errors++; $display("FAIL %s_frame: got %h want %h", tag, cap, exp_cmd(6'd8, 32'h000001AA)); end
      checks++; if (!gd || dones != 1) begin errors++; $display("FAIL %s_done: got seen=%0d count=%0d want 1 1", tag, gd, dones); end
      checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL %s_rsp_data: got %h want %h", tag, rsp_data, exp_rsp); end
      checks++; if (err_crc !== exp_err || err_timeout !== 1'b0) begin errors++; $display("FAIL %s_flags: got crc=%b tmo=%b want %b 0", tag, err_crc, err_timeout, exp_err); end
   endtask

   task automatic test_r2();
      logic [47:0] cap; int falls, rises, dones; bit gd, ob; logic bs; logic [1:0] es;
      logic [127:0] body; logic [135:0] frame;
      body  = {$urandom, $urandom, $urandom, $urandom};
      frame = {2'b00, 6'h3F, body[119:0], 7'($urandom), 1'b1};
      exp_rsp = frame[127:0];
      run_cmd(6'd2, 32'h0, 2'b10, 1'b1, frame, 136, 3, cap, falls, rises, dones, gd, ob, bs, es);
      checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL r2_rsp_data: got %h want %h", rsp_data, exp_rsp); end
      checks++; if (err_crc !== 1'b0 || err_timeout !== 1'b0 || dones != 1) begin errors++; $display("FAIL r2_flags: got crc=%b tmo=%b dones=%0d want 0 0 1", err_crc, err_timeout, dones); end
   endtask

   task automatic test_random();
      logic [47:0] cap; int falls, rises, dones; bit gd, ob; logic bs; logic [1:0] es;
      logic [1:0] typ; logic [5:0] idx; logic [31:0] arg, rarg; logic [6:0] c;
      logic [127:0] body; logic [135:0] frame; int flen, dly; logic expe;
      for (int k = 0; k < 8; k++) begin
         typ = 2'($urandom_range(0, 3));
         idx = 6'($urandom);
         arg = $urandom;
         dly = $urandom_range(1, 6);
         if (typ == 2'b10) begin
            body  = {$urandom, $urandom, $urandom, $urandom};
            frame = {2'b00, 6'h3F, body[119:0], 7'($urandom), 1'b1};
            flen  = 136;
            exp_rsp = frame[127:0];
         end else begin
            rarg = $urandom;
            c = crc7_div({2'b00, idx, rarg});
            if ($urandom_range(0, 1) == 1) c = c ^ 7'(1 << $urandom_range(0, 6));
            frame = {88'b0, 2'b00, idx, rarg, c, 1'b1};
            flen  = 48;
            if (typ != 2'b00) exp_rsp = {82'b0, frame[45:0]};
         end
         expe = exp_crc_err(typ, frame[47:0]);
         run_cmd(idx, arg, typ, typ != 2'b00, frame, flen, dly, cap, falls, rises, dones, gd, ob, bs, es);
         checks++; if (cap !== exp_cmd(idx, arg)) begin errors++; $display("FAIL rand%0d_frame: got %h want %h", k, cap, exp_cmd(idx, arg)); end
         checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL rand%0d_rsp_data: type %b got %h want %h", k, typ, rsp_data, exp_rsp); end
         checks++; if (err_crc !== expe || err_timeout !== 1'b0) begin errors++; $display("FAIL rand%0d_flags: type %b got crc=%b tmo=%b want %b 0", k, typ, err_crc, err_timeout, expe); end
         checks++; if (!gd || dones != 1 || ob) begin errors++; $display("FAIL rand%0d_done: got seen=%0d count=%0d oe_bad=%0d want 1 1 0", k, gd, dones, ob); end
      end
   endtask

   task automatic test_reset_mid();
      logic [47:0] cap, expf; int n, d0;
      int falls, rises, dones; bit gd, ob; logic bs; logic [1:0] es;
      expf = exp_cmd(6'd17, 32'hDEADBEEF);
      @(negedge clk);
      cmd_idx = 6'd17; cmd_arg = 32'hDEADBEEF; rsp_type = 2'b01; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      d0 = done_cnt;
      n = 0;
      while (sd_cmd_oe !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      cap = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge sd_clk); @(negedge clk);
         cap = {cap[46:0], sd_cmd_out_o};
         if (i == 8) begin
            cmd_idx = 6'd55; cmd_arg = 32'h12345678; rsp_type = 2'b00; cmd_start = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
         end
      end
      checks++; if (cap[19:0] !== expf[47:28]) begin errors++; $display("FAIL mid_ignore: got %h want %h", cap[19:0], expf[47:28]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
      #3 rst = 1'b0;
      #1;
      checks++; if ({sd_clk, sd_cmd_out_o, sd_cmd_oe, busy, done} !== 5'b01000) begin errors++; $display("FAIL mid_reset_out: got clk/out/oe/busy/done=%b want 01000", {sd_clk, sd_cmd_out_o, sd_cmd_oe, busy, done}); end
      checks++; if (rsp_data !== 128'b0 || err_timeout !== 1'b0 || err_crc !== 1'b0) begin errors++; $display("FAIL mid_reset_data: got rsp=%h tmo=%b crc=%b want 0", rsp_data, err_timeout, err_crc); end
      exp_rsp = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (800) @(negedge clk);
      checks++; if (done_cnt != d0 || busy !== 1'b0 || sd_cmd_oe !== 1'b0) begin errors++; $display("FAIL mid_no_done: got dones=%0d busy=%b oe=%b want 0 0 0", done_cnt - d0, busy, sd_cmd_oe); end
      run_cmd(6'd0, 32'h0, 2'b00, 1'b0, '0, 48, 1, cap, falls, rises, dones, gd, ob, bs, es);
      checks++; if (cap !== 48'h400000000095 || dones != 1) begin errors++; $display("FAIL mid_after: got frame %h dones %0d want 400000000095 1", cap, dones); end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_timeout();
      test_cmd8(48'h08000001AA13, 1'b0, "cmd8");
      test_cmd8(48'h08000001AA15, CRC_EN, "cmd8_badcrc");
      test_r2();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
